// File: rtl/mod_counter_prescaled_if.sv
// Control/status bundle for mod_counter_prescaled: board-side controls in,
// count value and status flags out.
interface mod_counter_prescaled_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrap;
    logic             done;

    modport master (
        output enable, up, mode, load, load_value,
        input  Q, tc, wrap, done
    );

    modport slave (
        input  enable, up, mode, load, load_value,
        output Q, tc, wrap, done
    );
endinterface

// File: rtl/mod_counter_prescaled.sv
// Parametrised modulo up/down counter with clock-enable prescaler, parallel
// load and run-time selectable wrap / saturate / one-shot terminal behaviour.
module mod_counter_prescaled #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     clear,
    mod_counter_prescaled_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [15:0]      PS_LAST = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic [15:0]      r_ps;
    logic             r_wrap;
    logic             r_done;

    logic [WIDTH-1:0] w_loadClamped;
    logic             w_atTerminal;
    logic             w_stepNow;
    mode_t            w_mode;

    assign w_mode        = mode_t'(bus.mode);
    assign w_loadClamped = (64'(bus.load_value) > 64'(MODULUS - 1)) ? MAX_Q : bus.load_value;
    // Terminal is compared before any arithmetic so MODULUS = 2^WIDTH never overflows.
    assign w_atTerminal  = bus.up ? (r_q == MAX_Q) : (r_q == '0);
    assign w_stepNow     = bus.enable && !r_done && (r_ps == PS_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q    <= '0;
            r_ps   <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (bus.load) begin
            r_q    <= w_loadClamped;
            r_ps   <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            // A finished one-shot freezes both the prescaler and the count.
            if (bus.enable && !r_done) begin
                if (w_stepNow) begin
                    r_ps <= '0;
                    if (!w_atTerminal) begin
                        r_q <= bus.up ? r_q + 1'b1 : r_q - 1'b1;
                    end else begin
                        case (w_mode)
                            MODE_SAT: begin
                                r_q <= r_q;
                            end
                            MODE_ONESHOT: begin
                                r_done <= 1'b1;
                            end
                            default: begin
                                r_q    <= bus.up ? '0 : MAX_Q;
                                r_wrap <= 1'b1;
                            end
                        endcase
                    end
                end else begin
                    r_ps <= r_ps + 16'd1;
                end
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.tc   = w_atTerminal;
    assign bus.wrap = r_wrap;
    assign bus.done = r_done;
endmodule
